// File: rtl/seq_alu_if.sv
// Operand/result bus between the control unit and the sequential ALU.
// The master issues start/op/a/b; the slave returns {HI,LO} plus status.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [3:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] z;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic               illegal;

  modport master (
    output start, op, a, b,
    input  z, busy, done, div_zero, illegal
  );

  modport slave (
    input  start, op, a, b,
    output z, busy, done, div_zero, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift ops, radix-2 Booth multiply and
// signed restoring divide, all behind a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      clr,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_END = WIDTH[SHW:0];

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ALU  = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_FIX  = 3'd4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  logic [2:0]         state;
  logic [3:0]         opr;
  logic [WIDTH-1:0]   ar, br;
  logic [SHW:0]       cnt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mq;
  logic               q_1;
  logic [WIDTH-1:0]   rem, quo;
  logic [2*WIDTH-1:0] z_q;
  logic               busy_q, done_q, dz_q, ill_q;

  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic [WIDTH-1:0]   alu_lo, alu_hi;
  logic               alu_dz, alu_ill;
  logic [WIDTH:0]     m_ext, acc_nxt;
  logic [WIDTH-1:0]   mag_a, mag_b, q_fix, r_fix;
  logic [WIDTH:0]     rem_sh, diff;

  assign sh    = br[SHW-1:0];
  assign rot_r = {ar, ar} >> sh;
  assign rot_l = {ar, ar} << sh;

  always_comb begin
    alu_lo  = '0;
    alu_hi  = '0;
    alu_dz  = 1'b0;
    alu_ill = 1'b0;
    case (opr)
      OP_ADD:  alu_lo = ar + br;
      OP_SUB:  alu_lo = ar - br;
      OP_AND:  alu_lo = ar & br;
      OP_OR:   alu_lo = ar | br;
      OP_SHR:  alu_lo = ar >> sh;
      OP_SHRA: alu_lo = $signed(ar) >>> sh;
      OP_SHL:  alu_lo = ar << sh;
      OP_ROR:  alu_lo = rot_r[WIDTH-1:0];
      OP_ROL:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
      OP_NEG:  alu_lo = -ar;
      OP_NOT:  alu_lo = ~ar;
      // Only a zero divisor reaches the single-cycle path with a DIV code
      OP_DIV: begin
        alu_lo = '1;
        alu_hi = ar;
        alu_dz = 1'b1;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // Booth step: the accumulator carries one extra sign bit so that a
  // most-negative multiplicand cannot overflow it
  assign m_ext = {br[WIDTH-1], br};
  always_comb begin
    case ({mq[0], q_1})
      2'b01:   acc_nxt = acc + m_ext;
      2'b10:   acc_nxt = acc - m_ext;
      default: acc_nxt = acc;
    endcase
  end

  assign mag_a  = ar[WIDTH-1] ? -ar : ar;
  assign mag_b  = br[WIDTH-1] ? -br : br;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, mag_b};
  assign q_fix  = (ar[WIDTH-1] ^ br[WIDTH-1]) ? -quo : quo;
  assign r_fix  = ar[WIDTH-1] ? -rem : rem;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      opr    <= '0;
      ar     <= '0;
      br     <= '0;
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      q_1    <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      z_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            opr    <= bus.op;
            ar     <= bus.a;
            br     <= bus.b;
            busy_q <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mq     <= bus.a;
            q_1    <= 1'b0;
            if (bus.op == OP_MUL)
              state <= S_MUL;
            else if (bus.op == OP_DIV && bus.b != '0)
              state <= S_DIV;
            else
              state <= S_ALU;
          end
        end
        S_ALU: begin
          z_q    <= {alu_hi, alu_lo};
          dz_q   <= alu_dz;
          ill_q  <= alu_ill;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        S_MUL: begin
          if (cnt == CNT_END) begin
            z_q    <= {acc[WIDTH-1:0], mq};
            dz_q   <= 1'b0;
            ill_q  <= 1'b0;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            {acc, mq, q_1} <= {acc_nxt[WIDTH], acc_nxt, mq};
            cnt <= cnt + 1'b1;
          end
        end
        // First DIV cycle loads magnitudes, the next WIDTH cycles iterate
        S_DIV: begin
          if (cnt == '0) begin
            rem <= '0;
            quo <= mag_a;
          end else if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          if (cnt == CNT_END)
            state <= S_FIX;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          z_q    <= {r_fix, q_fix};
          dz_q   <= 1'b0;
          ill_q  <= 1'b0;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.z        = z_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.illegal  = ill_q;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle datapath ALU for the mini SRC CPU; replaces the purely combinational ALU.
- Adds sequential radix-2 Booth multiply and signed restoring divide, plus full shift/rotate set, behind a start/busy/done handshake.
- Drives a 2*WIDTH result (upper half = HI, lower half = LO) into the Z register path.

Parameters:
WIDTH, 32, operand width; power of 2, >= 4. SHW = log2(WIDTH) is derived internally and is the shift-amount width.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
start  input  1  request; sampled on rising edge, accepted only when busy=0
op  input  4  operation select, latched on accept
a  input  WIDTH  operand A, latched on accept
b  input  WIDTH  operand B, latched on accept
z  output  2*WIDTH  result {HI,LO}; holds until the next completion
busy  output  1  operation in progress
done  output  1  one-cycle pulse, z valid
div_zero  output  1  last completed DIV had b=0
illegal  output  1  last completed op code was undefined

Behaviour:
- Reset: asynchronous on clr high; z=0, busy=0, done=0, div_zero=0, illegal=0, FSM=IDLE. Any operation in progress is aborted; no done pulse.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR
  - 4 SHR logical, 5 SHRA arithmetic, 6 SHL, 7 ROR, 8 ROL
  - 9 MUL, 10 DIV, 11 NEG (two's complement), 12 NOT (bitwise)
  - 13-15 illegal
- Single-width ops (0-8, 11, 12): result in LO, HI=0. ADD/SUB wrap modulo 2^WIDTH with no carry out. Shift/rotate amount = b[SHW-1:0]; higher bits of b are ignored.
- MUL: signed x signed, full 2*WIDTH product in z. Radix-2 Booth, one iteration per cycle.
- DIV: signed, truncating toward zero. LO = quotient, HI = remainder; the remainder takes the dividend's sign.
  - Procedure: magnitudes, WIDTH restoring iterations, then one sign-fixup cycle.
  - b=0: LO = all ones, HI = a, div_zero=1.
  - Most-negative / -1: LO = most-negative (wraps), HI = 0.
- div_zero and illegal update on every completion: set for the qualifying case, cleared otherwise.
- FSM states: IDLE, ALU, MUL, DIV, FIX.
  - IDLE: on accepted start go to ALU (ops 0-8, 11-15), MUL, or DIV (b=0 goes to ALU path and completes as the div-by-zero case).
  - ALU: one cycle, then IDLE.
  - MUL: WIDTH cycles, then IDLE.
  - DIV: WIDTH cycles, then FIX.
  - FIX: one cycle, then IDLE.
- Latency, with start accepted at edge k: z, done and flags are registered at edge k+L.
  - L = 1 for ALU ops, illegal ops and div-by-zero.
  - L = WIDTH+1 for MUL.
  - L = WIDTH+2 for DIV (non-zero divisor).
- busy: rises at edge k, falls at edge k+L, the same edge at which done rises. done is high for exactly one cycle.
- start with busy=1 is ignored; operand and op changes are also ignored while busy.
- start during the done cycle (busy=0) is accepted, giving back-to-back operation with no idle cycle.
- Illegal op: z=0, illegal=1, L=1.
- z changes only at completion or reset.

Test Plan:
1. WIDTH=32, MUL a=0xFFFFFFF9 (-7), b=6 -> done exactly 33 cycles after accept; z=0xFFFFFFFF_FFFFFFD6; busy high for 33 cycles.
2. DIV a=-17, b=5 -> done 34 cycles after accept; z=0xFFFFFFFE_FFFFFFFD. Then DIV a=0x80000000, b=0xFFFFFFFF -> z=0x00000000_80000000, div_zero=0.
3. DIV a=0x1234, b=0 -> done after 1 cycle; z=0x00001234_FFFFFFFF, div_zero=1. Following ADD 1+1 -> z=2, div_zero=0.
4. Shifts and misc ops:
   - ROL a=0x80000001, b=4 -> LO=0x00000018
   - SHRA a=0x80000000, b=0x3F -> LO=0xFFFFFFFF (amount 31)
   - SHR same operands -> LO=0x00000001
   - op=14 -> z=0, illegal=1
   - HI=0 in all cases
5. Handshake:
   - MUL 3x4 started; ADD 5+6 with start pulsed mid-MUL -> ignored; z=12 at done.
   - ADD 5+6 issued in the done cycle -> accepted; z=11 one cycle later.
6. Reset mid-op: assert clr 10 cycles into DIV 100/7 -> z=0, busy=0, no done. After release, SUB 3-4 -> z=0x00000000_FFFFFFFF after 1 cycle.
